// File: rtl/ram_op_sequencer.sv
// ram_op_sequencer
// Command initiator for the 3-port operand RAM. For each accepted command it
// reads operands A and B through the registered read ports, runs them through
// a small ALU and writes the result back through the write port. One command
// is in flight at a time: IDLE -> READ -> EXEC -> WRITE -> IDLE.
module ram_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_z,
    output logic [ADDR_W-1:0] Addr_A,
    input  logic [DATA_W-1:0] Data_A,
    output logic [ADDR_W-1:0] Addr_B,
    input  logic [DATA_W-1:0] Data_B,
    output logic [ADDR_W-1:0] Addr_C,
    output logic [DATA_W-1:0] Data_C,
    output logic              WE_C,
    output logic              busy,
    output logic              done,
    output logic              flag_c,
    output logic              flag_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    state_t              state;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_z_q;
    logic                carry_q;
    logic                we_q;
    logic                done_q;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;

    // ALU: operands come straight from the RAM read data, valid during EXEC
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        sum_ext    = {1'b0, Data_A} + {1'b0, Data_B};
        diff_ext   = {1'b0, Data_A} - {1'b0, Data_B};
        case (op_q)
            OP_ADD: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_carry  = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_carry  = diff_ext[DATA_W];
            end
            OP_AND:  alu_result = Data_A & Data_B;
            OP_OR:   alu_result = Data_A | Data_B;
            OP_XOR:  alu_result = Data_A ^ Data_B;
            OP_PASS: alu_result = Data_A;
            OP_SHL: begin
                alu_result = {Data_A[DATA_W-2:0], 1'b0};
                alu_carry  = Data_A[DATA_W-1];
            end
            OP_SHR: begin
                alu_result = {1'b0, Data_A[DATA_W-1:1]};
                alu_carry  = Data_A[0];
            end
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered handshake, RAM address/data and flag outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            carry_q   <= 1'b0;
            op_q      <= '0;
            addr_z_q  <= '0;
            Addr_A    <= '0;
            Addr_B    <= '0;
            Addr_C    <= '0;
            Data_C    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        Addr_A    <= cmd_addr_a;
                        Addr_B    <= cmd_addr_b;
                        addr_z_q  <= cmd_addr_z;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    Data_C  <= alu_result;
                    carry_q <= alu_carry;
                    Addr_C  <= addr_z_q;
                    we_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    we_q      <= 1'b0;
                    done_q    <= 1'b0;
                    flag_c    <= carry_q;
                    flag_z    <= (Data_C == '0);
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving mid-WRITE must not leak a partial write into the RAM
    assign WE_C = we_q & ~RST;
    assign done = done_q & ~RST;

endmodule

// File: tb/tb_ram_op_sequencer.sv
// tb_ram_op_sequencer
// Directed bench for ram_op_sequencer with a behavioural 3-port RAM. Expected
// write-backs are queued as commands are issued; a monitor checks every WE_C.
module tb_ram_op_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_addr_a = '0;
    logic [7:0] cmd_addr_b = '0;
    logic [7:0] cmd_addr_z = '0;
    logic [7:0] Addr_A, Addr_B, Addr_C;
    logic [7:0] Data_A, Data_B, Data_C;
    logic       WE_C, busy, done, flag_c, flag_z;

    logic [7:0] mem [0:255];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       c;
        logic       z;
    } exp_t;

    exp_t expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int lastAccept  = 0;
    logic flagsPending = 1'b0;
    logic expFlagC = 1'b0;
    logic expFlagZ = 1'b0;

    ram_op_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_z(cmd_addr_z),
        .Addr_A(Addr_A), .Data_A(Data_A), .Addr_B(Addr_B), .Data_B(Data_B),
        .Addr_C(Addr_C), .Data_C(Data_C), .WE_C(WE_C),
        .busy(busy), .done(done), .flag_c(flag_c), .flag_z(flag_z)
    );

    always #5 CLK = ~CLK;

    // Operand RAM: registered read ports, synchronous write port
    always @(posedge CLK) begin
        Data_A <= mem[Addr_A];
        Data_B <= mem[Addr_B];
        if (WE_C) mem[Addr_C] <= Data_C;
    end

    // Cycle counter and accept-edge recorder
    always @(posedge CLK) begin
        if (!RST && cmd_valid && cmd_ready) lastAccept = cyc + 1;
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compare every write-back against the scoreboard, then the flags
    always @(negedge CLK) begin
        exp_t e;
        if (flagsPending) begin
            checkOutput("flag_c", flag_c, expFlagC);
            checkOutput("flag_z", flag_z, expFlagZ);
            flagsPending = 1'b0;
        end
        if (WE_C) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_write: got write addr 0x%0h data 0x%0h, expected none",
                         Addr_C, Data_C);
            end else begin
                e = expQ.pop_front();
                checkOutput("Addr_C", Addr_C, e.addr);
                checkOutput("Data_C", Data_C, e.data);
                checkOutput("done", done, 1);
                checkOutput("latency", cyc + 1 - lastAccept, 3);
                expFlagC = e.c;
                expFlagZ = e.z;
                flagsPending = 1'b1;
            end
        end else begin
            if (done) checkOutput("done_without_we", done, 0);
        end
    end

    function automatic void expect_write(input logic [7:0] addr, input logic [7:0] data,
                                         input logic c, input logic z);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.c    = c;
        e.z    = z;
        expQ.push_back(e);
    endfunction

    // Offer a command at a negedge, wait for its accept edge, return at the next negedge
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] z, input logic keep, output int accCyc);
        int n;
        n = 0;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_z = z;
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        accCyc = -1;
        if (!cmd_ready) begin
            checkOutput("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1 accCyc = cyc;
            @(negedge CLK);
            if (!keep) cmd_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || expQ.size() != 0) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (busy || expQ.size() != 0) checkOutput("idle_timeout", 0, 1);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int acc1, acc2;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", WE_C, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_flag_c", flag_c, 0);
        checkOutput("rst_flag_z", flag_z, 0);
        checkOutput("rst_addr_a", Addr_A, 0);
        checkOutput("rst_addr_c", Addr_C, 0);
        checkOutput("rst_data_c", Data_C, 0);
        RST = 1'b0;
        @(negedge CLK);

        // T1: ADD 5+3
        mem[1] = 8'h05; mem[2] = 8'h03;
        expect_write(8'd3, 8'h08, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'd1, 8'd2, 8'd3, 1'b0, acc1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_ready_low", cmd_ready, 0);
        waitIdle();
        checkOutput("t1_mem3", mem[3], 8'h08);

        // T2: ADD with carry and zero result
        mem[1] = 8'hFF; mem[2] = 8'h01;
        expect_write(8'd4, 8'h00, 1'b1, 1'b1);
        applyStimulus(3'd0, 8'd1, 8'd2, 8'd4, 1'b0, acc1);
        waitIdle();

        // T3: SUB with borrow, then SHR shifting out a one
        mem[1] = 8'h03; mem[2] = 8'h05; mem[9] = 8'h81;
        expect_write(8'd8, 8'hFE, 1'b1, 1'b0);
        applyStimulus(3'd1, 8'd1, 8'd2, 8'd8, 1'b0, acc1);
        waitIdle();
        expect_write(8'd10, 8'h40, 1'b1, 1'b0);
        applyStimulus(3'd7, 8'd9, 8'd0, 8'd10, 1'b0, acc1);
        waitIdle();

        // SHL, AND, OR coverage
        mem[11] = 8'hC3; mem[12] = 8'hF0; mem[13] = 8'h3C;
        expect_write(8'd20, 8'h86, 1'b1, 1'b0);
        applyStimulus(3'd6, 8'd11, 8'd0, 8'd20, 1'b0, acc1);
        waitIdle();
        expect_write(8'd21, 8'h30, 1'b0, 1'b0);
        applyStimulus(3'd2, 8'd12, 8'd13, 8'd21, 1'b0, acc1);
        waitIdle();
        expect_write(8'd22, 8'hFC, 1'b0, 1'b0);
        applyStimulus(3'd3, 8'd12, 8'd13, 8'd22, 1'b0, acc1);
        waitIdle();

        // T4: back-to-back with cmd_valid held, RAW through address 5
        mem[1] = 8'h20; mem[2] = 8'h22;
        expect_write(8'd5, 8'h42, 1'b0, 1'b0);
        expect_write(8'd6, 8'h42, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'd1, 8'd2, 8'd5, 1'b1, acc1);
        applyStimulus(3'd5, 8'd5, 8'd0, 8'd6, 1'b0, acc2);
        checkOutput("t4_accept_gap", acc2 - acc1, 4);
        waitIdle();
        checkOutput("t4_mem6", mem[6], 8'h42);

        // T5: reset during EXEC discards the command
        mem[12] = 8'h55; mem[13] = 8'h0F; mem[14] = 8'hAA;
        applyStimulus(3'd0, 8'd12, 8'd13, 8'd14, 1'b0, acc1);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_ready", cmd_ready, 1);
        checkOutput("t5_we", WE_C, 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("t5_mem14", mem[14], 8'hAA);
        expect_write(8'd15, 8'h64, 1'b0, 1'b0);
        applyStimulus(3'd0, 8'd12, 8'd13, 8'd15, 1'b0, acc1);
        waitIdle();

        // Reset raised inside WRITE must suppress the write strobe
        mem[16] = 8'h77;
        applyStimulus(3'd5, 8'd12, 8'd0, 8'd16, 1'b0, acc1);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        checkOutput("t5b_we_gated", WE_C, 0);
        checkOutput("t5b_done_gated", done, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("t5b_mem16", mem[16], 8'h77);

        // T6: same address for A, B and Z
        mem[7] = 8'h11;
        expect_write(8'd7, 8'h00, 1'b0, 1'b1);
        applyStimulus(3'd4, 8'd7, 8'd7, 8'd7, 1'b0, acc1);
        waitIdle();
        checkOutput("t6_mem7", mem[7], 8'h00);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
